// File: rtl/corelet_pkg.sv
// corelet_pkg: shared inst-bus bit positions and sequencer states for the corelet controller
package corelet_pkg;
    localparam int OFIFO_RD = 6;
    localparam int IFIFO_WR = 5;
    localparam int IFIFO_RD = 4;
    localparam int L0_RD    = 3;
    localparam int L0_WR    = 2;
    localparam int EXEC     = 1;
    localparam int KLOAD    = 0;
    typedef enum logic [2:0] {
        S_IDLE, S_W_FILL, S_W_LOAD, S_W_FLUSH, S_EXEC, S_DRAIN, S_DONE
    } state_t;
endpackage

// File: rtl/l0_occ_tracker.sv
// l0_occ_tracker: L0 occupancy and in-flight xmem read bookkeeping, gates new reads so L0 cannot overflow
module l0_occ_tracker
    import corelet_pkg::*;
#(
    parameter int l0_depth = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic issue,
    input  logic rd,
    output logic wr,
    output logic occ_nz,
    output logic can_issue
);
    localparam int OW = $clog2(l0_depth + 1) + 1;
    logic [OW-1:0] occ, inflight;
    // a read issued this cycle lands as l0_wr next cycle; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            wr       <= 1'b0;
            occ      <= '0;
            inflight <= '0;
        end else begin
            wr       <= issue;
            occ      <= occ + OW'(wr) - OW'(rd);
            inflight <= inflight + OW'(issue) - OW'(wr);
        end
    end
    assign occ_nz    = occ != '0;
    assign can_issue = (occ + inflight) < OW'(l0_depth);
endmodule

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequences kernel load and execute passes through L0, MAC array and OFIFO into pmem
module corelet_ctrl
    import corelet_pkg::*;
#(
    parameter int bw       = 4,
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int psum_bw  = 16,
    parameter int addr_w   = 11,
    parameter int l0_depth = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] w_base,
    input  logic [addr_w-1:0] a_base,
    input  logic [addr_w-1:0] p_base,
    input  logic [addr_w-1:0] act_len,
    input  logic              ofifo_valid,
    output logic [6:0]        inst,
    output logic              xmem_cen,
    output logic [addr_w-1:0] xmem_addr,
    output logic              pmem_cen,
    output logic              pmem_wen,
    output logic [addr_w-1:0] pmem_addr,
    output logic              busy,
    output logic              done
);
    localparam logic [addr_w-1:0] COL    = addr_w'(col);
    localparam logic [addr_w-1:0] COL_M1 = addr_w'(col - 1);
    localparam logic [addr_w-1:0] FL_M1  = addr_w'(row + col - 1);

    if (bw < 1 || psum_bw < 1 || l0_depth < col) begin : g_bad_params
        $error("corelet_ctrl: invalid parameters");
    end

    state_t state, state_nxt;
    logic [addr_w-1:0] w_r, a_r, p_r, len_r, rcnt, ecnt, k, cyc;
    logic issue, kload, exec_rd, drain, l0_rd, l0_wr, occ_nz, can_issue;

    l0_occ_tracker #(.l0_depth(l0_depth)) u_occ (
        .clk(clk), .reset(reset), .issue(issue), .rd(l0_rd),
        .wr(l0_wr), .occ_nz(occ_nz), .can_issue(can_issue)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // next state and per-cycle strobes; drain stops once every psum row is written
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        kload     = 1'b0;
        exec_rd   = 1'b0;
        drain     = 1'b0;
        unique case (state)
            S_IDLE:    state_nxt = start ? S_W_FILL : S_IDLE;
            S_W_FILL: begin
                issue     = rcnt != COL && can_issue;
                state_nxt = (rcnt == COL && l0_wr) ? S_W_LOAD : S_W_FILL;
            end
            S_W_LOAD: begin
                kload     = 1'b1;
                state_nxt = cyc == COL_M1 ? S_W_FLUSH : S_W_LOAD;
            end
            S_W_FLUSH: state_nxt = cyc == FL_M1 ? S_EXEC : S_W_FLUSH;
            S_EXEC: begin
                issue     = rcnt != len_r && can_issue;
                exec_rd   = occ_nz;
                drain     = ofifo_valid && k != len_r;
                state_nxt = (exec_rd && ecnt == len_r - 1'b1) ? S_DRAIN : S_EXEC;
            end
            S_DRAIN: begin
                drain     = ofifo_valid && k != len_r;
                state_nxt = k == len_r ? S_DONE : S_DRAIN;
            end
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // latch run parameters on an accepted start and advance the address/count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            {w_r, a_r, p_r, len_r, rcnt, ecnt, k, cyc} <= '0;
        end else begin
            cyc <= state_nxt != state ? '0 : cyc + 1'b1;
            if (state == S_IDLE && start) begin
                w_r   <= w_base;
                a_r   <= a_base;
                p_r   <= p_base;
                len_r <= act_len == '0 ? addr_w'(1) : act_len;
                rcnt  <= '0;
                ecnt  <= '0;
                k     <= '0;
            end else begin
                if (state == S_W_FLUSH) rcnt <= '0;
                else if (issue)         rcnt <= rcnt + 1'b1;
                if (exec_rd) ecnt <= ecnt + 1'b1;
                if (drain)   k    <= k + 1'b1;
            end
        end
    end

    // inst bus assembly; the input-FIFO bits are unused by this sequencer
    always_comb begin
        l0_rd          = kload | exec_rd;
        inst           = '0;
        inst[OFIFO_RD] = drain;
        inst[IFIFO_WR] = 1'b0;
        inst[IFIFO_RD] = 1'b0;
        inst[L0_RD]    = l0_rd;
        inst[L0_WR]    = l0_wr;
        inst[EXEC]     = exec_rd;
        inst[KLOAD]    = kload;
    end

    assign xmem_cen  = ~issue;
    assign xmem_addr = (state == S_W_FILL ? w_r : a_r) + rcnt;
    assign pmem_cen  = ~drain;
    assign pmem_wen  = ~drain;
    assign pmem_addr = p_r + k;
    assign busy      = state != S_IDLE && state != S_DONE;
    assign done      = state == S_DONE;
endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: directed checks of the corelet sequencer with an OFIFO stub and an L0 occupancy model
module tb_corelet_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] w_base = '0, a_base = '0, p_base = '0, act_len = '0;
    logic        ofifo_valid = 1'b0;
    logic [6:0]  inst;
    logic        xmem_cen, pmem_cen, pmem_wen, busy, done;
    logic [10:0] xmem_addr, pmem_addr;

    corelet_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .w_base(w_base), .a_base(a_base),
        .p_base(p_base), .act_len(act_len), .ofifo_valid(ofifo_valid), .inst(inst),
        .xmem_cen(xmem_cen), .xmem_addr(xmem_addr), .pmem_cen(pmem_cen),
        .pmem_wen(pmem_wen), .pmem_addr(pmem_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int tcyc = 0, done_cnt = 0, wr_cnt = 0, occ_m = 0, occ_max = 0, under = 0, ov_left = 0;
    int iq[$], xq[$], xcyc[$], pq[$];
    logic tog = 1'b0;

    // OFIFO stub: offers a row every other cycle while rows remain
    always @(posedge clk) begin
        #1;
        ofifo_valid = (ov_left > 0) && tog;
        tog = ~tog;
    end

    // monitor: trace inst, xmem reads, pmem writes, done pulses and modelled L0 occupancy
    always @(negedge clk) begin
        if (reset) begin
            occ_m = 0;
        end else begin
            if (busy) begin
                iq.push_back(int'(inst));
                if (!xmem_cen) begin
                    xq.push_back(int'(xmem_addr));
                    xcyc.push_back(tcyc);
                end
                tcyc++;
            end
            if (!pmem_cen && !pmem_wen) begin
                pq.push_back(int'(pmem_addr));
                if (ov_left > 0) ov_left--;
            end
            if (done) done_cnt++;
            if (inst[2]) wr_cnt++;
            if (inst[3] && occ_m == 0) under++;
            occ_m = occ_m + int'(inst[2]) - int'(inst[3]);
            if (occ_m > occ_max) occ_max = occ_m;
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int w, input int a, input int p, input int len);
        tcyc = 0; occ_max = 0; under = 0;
        iq.delete(); xq.delete(); xcyc.delete(); pq.delete();
        w_base = 11'(w); a_base = 11'(a); p_base = 11'(p); act_len = 11'(len);
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < lim) begin
            tick;
            n++;
        end
        chk(tag, int'(done_cnt != d0), 1);
        tick;
    endtask

    function automatic int exp_inst(input int i);
        return (i == 0) ? 0 : (i <= 8) ? 4 : (i <= 16) ? 9 : 0;
    endfunction

    initial begin
        int d0, w0, n;
        // reset state
        repeat (3) tick;
        @(negedge clk);
        chk("rst_inst", int'(inst), 0);
        chk("rst_xcen", int'(xmem_cen), 1);
        chk("rst_pcen", int'(pmem_cen), 1);
        chk("rst_pwen", int'(pmem_wen), 1);
        chk("rst_xaddr", int'(xmem_addr), 0);
        chk("rst_paddr", int'(pmem_addr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        tick;
        reset = 1'b0;
        tick;

        // basic run: weights 0..7, activations 8..11, four psum rows
        d0 = done_cnt;
        ov_left = 4;
        start_run(0, 8, 0, 4);
        wait_done("t1_done", 400);
        chk("t1_xq_size", xq.size(), 12);
        for (int i = 0; i < 12; i++) chk("t1_xaddr", xq[i], i);
        for (int i = 0; i < 8; i++) chk("t1_wcyc", xcyc[i], i);
        for (int i = 8; i < 12; i++) chk("t1_acyc", xcyc[i], 25 + i);
        for (int i = 0; i < 33; i++) chk("t1_inst", iq[i], exp_inst(i));
        chk("t2_pq_size", pq.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_paddr", pq[i], i);
        chk("t2_done_once", done_cnt - d0, 1);
        chk("t2_busy_after", int'(busy), 0);
        chk("t2_under", under, 0);

        // long run: occupancy bound and every activation read exactly once
        d0 = done_cnt;
        ov_left = 100;
        start_run(0, 100, 200, 100);
        wait_done("t3_done", 2000);
        chk("t3_occ_max_le64", int'(occ_max <= 64), 1);
        chk("t3_under", under, 0);
        chk("t3_xq_size", xq.size(), 108);
        for (int i = 0; i < 100; i++) chk("t3_xaddr", xq[8 + i], 100 + i);
        chk("t3_pq_size", pq.size(), 100);
        chk("t3_plast", pq[99], 299);
        chk("t3_done_once", done_cnt - d0, 1);

        // reset while reads are in flight during EXEC
        ov_left = 4;
        start_run(0, 8, 0, 4);
        n = 0;
        while (tcyc < 36 && n < 200) begin
            tick;
            n++;
        end
        chk("t4_reached_exec", int'(tcyc >= 36), 1);
        ov_left = 0;
        reset = 1'b1;
        tick;
        @(negedge clk);
        chk("t4_inst", int'(inst), 0);
        chk("t4_xcen", int'(xmem_cen), 1);
        chk("t4_busy", int'(busy), 0);
        w0 = wr_cnt;
        tick;
        reset = 1'b0;
        repeat (4) tick;
        chk("t4_no_l0wr", wr_cnt - w0, 0);
        d0 = done_cnt;
        ov_left = 3;
        start_run(0, 20, 30, 3);
        wait_done("t4_rerun_done", 400);
        chk("t4_rerun_xa", xq[8], 20);
        chk("t4_rerun_pq_size", pq.size(), 3);
        chk("t4_rerun_p0", pq[0], 30);
        chk("t4_rerun_once", done_cnt - d0, 1);

        // stray starts in W_FILL and DRAIN are ignored
        d0 = done_cnt;
        ov_left = 0;
        start_run(0, 40, 50, 4);
        repeat (3) tick;
        w_base = 11'd700; a_base = 11'd700; p_base = 11'd700; act_len = 11'd9;
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (tcyc < 45 && n < 200) begin
            tick;
            n++;
        end
        start = 1'b1;
        tick;
        start = 1'b0;
        ov_left = 4;
        wait_done("t5_done", 400);
        chk("t5_xq_size", xq.size(), 12);
        chk("t5_xa0", xq[8], 40);
        chk("t5_xa3", xq[11], 43);
        chk("t5_pq_size", pq.size(), 4);
        chk("t5_p3", pq[3], 53);
        repeat (10) tick;
        chk("t5_done_once", done_cnt - d0, 1);
        chk("t5_busy_idle", int'(busy), 0);

        // address wrap on xmem and pmem
        ov_left = 4;
        start_run(10, 2046, 2045, 4);
        wait_done("t6_done", 400);
        chk("t6_w0", xq[0], 10);
        chk("t6_w7", xq[7], 17);
        chk("t6_a0", xq[8], 2046);
        chk("t6_a1", xq[9], 2047);
        chk("t6_a2", xq[10], 0);
        chk("t6_a3", xq[11], 1);
        chk("t6_p2", pq[2], 2047);
        chk("t6_p3", pq[3], 0);

        // act_len of zero behaves as one
        d0 = done_cnt;
        ov_left = 1;
        start_run(0, 5, 9, 0);
        wait_done("t7_done", 400);
        chk("t7_xq_size", xq.size(), 9);
        chk("t7_xa", xq[8], 5);
        chk("t7_pq_size", pq.size(), 1);
        chk("t7_p0", pq[0], 9);
        chk("t7_once", done_cnt - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
